// File: rtl/rgmii_pkg.sv
// rgmii_pkg: constants and types shared by the RGMII receive path.
package rgmii_pkg;
    localparam logic [7:0] SFD      = 8'hD5;
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_e;
endpackage

// File: rtl/rgmii_rx_iddr.sv
// rgmii_rx_iddr: same-edge-pipelined DDR capture of rxd[3:0] and ctrl into a GMII byte.
module rgmii_rx_iddr (
    input  logic       clk,
    input  logic       rx_ctrl,
    input  logic [3:0] rxd,
    output logic       rx_dv,
    output logic       rx_er,
    output logic [7:0] rx_byte
);
    logic [4:0] rise_q, fall_q, rise_p, fall_p;
    always_ff @(posedge clk) rise_q <= {rx_ctrl, rxd};
    always_ff @(negedge clk) fall_q <= {rx_ctrl, rxd};
    // Re-register both halves on the rising edge so the pair leaves together.
    always_ff @(posedge clk) begin
        rise_p <= rise_q;
        fall_p <= fall_q;
    end
    assign rx_dv   = rise_p[4];
    assign rx_er   = rise_p[4] ^ fall_p[4];
    assign rx_byte = {fall_p[3:0], rise_p[3:0]};
endmodule

// File: rtl/rgmii_rx_parser.sv
// rgmii_rx_parser: RGMII receive capture, preamble/SFD stripping, framing with length/error,
// in-band link status and good/bad frame counters.
module rgmii_rx_parser
    import rgmii_pkg::*;
#(
    parameter int PRE_MIN = 1,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic             rgmii_rxc,
    input  logic             sys_rst_n,
    input  logic             rgmii_rx_ctrl,
    input  logic [3:0]       rgmii_rxd,
    output logic             gmii_rx_dv,
    output logic             gmii_rx_er,
    output logic [7:0]       gmii_rxd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_err,
    output logic [LEN_W-1:0] rx_len,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_fdx,
    output logic [LEN_W-1:0] cnt_ok,
    output logic [LEN_W-1:0] cnt_bad
);
    rx_state_e        state;
    logic [3:0]       pcnt;
    logic [7:0]       hold;
    logic             hold_full, first, err_acc;
    logic [LEN_W-1:0] len;
    logic             is_pre, is_sfd, at_max, bad_end, status_ok;

    rgmii_rx_iddr u_iddr (
        .clk     (rgmii_rxc),
        .rx_ctrl (rgmii_rx_ctrl),
        .rxd     (rgmii_rxd),
        .rx_dv   (gmii_rx_dv),
        .rx_er   (gmii_rx_er),
        .rx_byte (gmii_rxd)
    );

    assign is_pre    = gmii_rxd == PRE_BYTE;
    assign is_sfd    = gmii_rxd == SFD && pcnt >= 4'(PRE_MIN);
    assign at_max    = len == LEN_W'(MAX_LEN);
    assign bad_end   = err_acc || len < LEN_W'(MIN_LEN);
    assign status_ok = !gmii_rx_dv && !gmii_rx_er && gmii_rxd[3:0] == gmii_rxd[7:4];

    always_ff @(posedge rgmii_rxc or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            pcnt       <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            first      <= 1'b0;
            err_acc    <= 1'b0;
            len        <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_err     <= 1'b0;
            rx_len     <= '0;
            link_up    <= 1'b0;
            link_speed <= SPEED_10M;
            link_fdx   <= 1'b0;
            cnt_ok     <= '0;
            cnt_bad    <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            if (status_ok) begin
                link_up    <= gmii_rxd[0];
                link_speed <= gmii_rxd[2:1];
                link_fdx   <= gmii_rxd[3];
            end
            case (state)
                IDLE: if (gmii_rx_dv) begin
                    state <= is_pre ? PRE : DROP;
                    pcnt  <= 4'd1;
                end
                PRE: if (!gmii_rx_dv) state <= IDLE;
                    else if (is_pre) pcnt <= (pcnt == 4'hF) ? pcnt : pcnt + 4'd1;
                    else if (is_sfd) begin
                        state     <= DATA;
                        hold_full <= 1'b0;
                        first     <= 1'b1;
                        err_acc   <= 1'b0;
                        len       <= '0;
                    end else state <= DROP;
                DATA: if (!gmii_rx_dv) begin
                        // A zero-byte frame emits nothing but still counts as bad.
                        state     <= IDLE;
                        hold_full <= 1'b0;
                        rx_valid  <= hold_full;
                        rx_data   <= hold;
                        rx_sof    <= hold_full && first;
                        rx_eof    <= hold_full;
                        rx_err    <= hold_full && bad_end;
                        rx_len    <= len;
                        if (bad_end) cnt_bad <= cnt_bad + LEN_W'(1);
                        else cnt_ok <= cnt_ok + LEN_W'(1);
                    end else if (at_max) begin
                        state     <= DROP;
                        hold_full <= 1'b0;
                        rx_valid  <= 1'b1;
                        rx_data   <= hold;
                        rx_sof    <= first;
                        rx_eof    <= 1'b1;
                        rx_err    <= 1'b1;
                        rx_len    <= len;
                        cnt_bad   <= cnt_bad + LEN_W'(1);
                    end else begin
                        rx_valid  <= hold_full;
                        rx_data   <= hold;
                        rx_sof    <= hold_full && first;
                        first     <= first && !hold_full;
                        hold      <= gmii_rxd;
                        hold_full <= 1'b1;
                        len       <= len + LEN_W'(1);
                        err_acc   <= err_acc || gmii_rx_er;
                    end
                DROP: if (!gmii_rx_dv) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgmii_rx_parser.sv
// tb_rgmii_rx_parser: frame-level scoreboard bench for the RGMII receive parser.
module tb_rgmii_rx_parser;
    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    logic        rgmii_rxc = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rgmii_rx_ctrl = 1'b0;
    logic [3:0]  rgmii_rxd = 4'h0;
    logic        gmii_rx_dv, gmii_rx_er, rx_valid, rx_sof, rx_eof, rx_err, link_up, link_fdx;
    logic [7:0]  gmii_rxd, rx_data;
    logic [15:0] rx_len, cnt_ok, cnt_bad;
    logic [1:0]  link_speed;

    rgmii_rx_parser dut (
        .rgmii_rxc(rgmii_rxc), .sys_rst_n(sys_rst_n), .rgmii_rx_ctrl(rgmii_rx_ctrl),
        .rgmii_rxd(rgmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rxd(gmii_rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_err(rx_err), .rx_len(rx_len), .link_up(link_up),
        .link_speed(link_speed), .link_fdx(link_fdx), .cnt_ok(cnt_ok), .cnt_bad(cnt_bad)
    );

    always #5 rgmii_rxc = ~rgmii_rxc;

    typedef struct packed {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [15:0] len;
    } ev_t;

    ev_t         got_q[$];
    ev_t         exp_q[$];
    logic [7:0]  pl[0:2047];
    bit          pe[0:2047];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_ok = 0, exp_bad = 0;
    logic        exp_up = 0, exp_fdx = 0;
    logic [1:0]  exp_speed = 0;
    logic [7:0]  idle_b = 8'h00;

    always @(negedge rgmii_rxc)
        if (rx_valid) got_q.push_back(ev_t'{rx_data, rx_sof, rx_eof, rx_eof & rx_err, rx_eof ? rx_len : 16'd0});

    // One RGMII byte per clock: low nibble before the rising edge, high nibble before the falling edge.
    task automatic drive(input logic dv, input logic er, input logic [7:0] b);
        rgmii_rx_ctrl = dv;
        rgmii_rxd     = b[3:0];
        @(posedge rgmii_rxc); #1;
        rgmii_rx_ctrl = dv ^ er;
        rgmii_rxd     = b[7:4];
        @(negedge rgmii_rxc); #1;
        if (!dv && !er && b[3:0] == b[7:4]) begin
            exp_up    = b[0];
            exp_speed = b[2:1];
            exp_fdx   = b[3];
        end
    endtask

    // Sends preamble, SFD, pl[0..n-1] and an IFG, and appends the expected frame outcome.
    task automatic send_frame(input int pre_n, input int n, input int ifg);
        int m;
        bit bad;
        for (int i = 0; i < pre_n; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) drive(1'b1, pe[i], pl[i]);
        for (int i = 0; i < ifg; i++) drive(1'b0, 1'b0, idle_b);
        m   = n > MAX_LEN ? MAX_LEN : n;
        bad = n < MIN_LEN || n > MAX_LEN;
        for (int i = 0; i < m; i++) bad = bad | pe[i];
        for (int i = 0; i < m; i++)
            exp_q.push_back(ev_t'{pl[i], i == 0, i == m - 1, (i == m - 1) & bad, i == m - 1 ? 16'(m) : 16'd0});
        if (bad) exp_bad++;
        else exp_ok++;
    endtask

    task automatic fill(input int n, input bit rnd, input int er_at);
        for (int i = 0; i < n; i++) begin
            pl[i] = rnd ? 8'($urandom) : 8'(i);
            pe[i] = (i == er_at);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({rx_valid, rx_sof, rx_eof, rx_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000", {rx_valid, rx_sof, rx_eof, rx_err});
        end
        n_tests++;
        if ({rx_data, rx_len} !== 24'h0) begin
            n_fail++; $display("FAIL reset_data got %h/%h exp 0", rx_data, rx_len);
        end
        n_tests++;
        if ({link_up, link_speed, link_fdx, cnt_ok, cnt_bad} !== 36'h0) begin
            n_fail++; $display("FAIL reset_status got %b %b %b %h %h exp 0", link_up, link_speed, link_fdx, cnt_ok, cnt_bad);
        end
    endtask

    task automatic test_frames(input string name);
        int k = -1;
        repeat (4) drive(1'b0, 1'b0, idle_b);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (k < 0 && got_q[i] !== exp_q[i]) k = i;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s n_bytes got %0d exp %0d", name, got_q.size(), exp_q.size());
        end
        n_tests++;
        if (k >= 0) begin
            n_fail++; $display("FAIL %s ev[%0d] got %h exp %h", name, k, got_q[k], exp_q[k]);
        end
        n_tests++;
        if (cnt_ok !== exp_ok || cnt_bad !== exp_bad) begin
            n_fail++; $display("FAIL %s counters got ok=%0d bad=%0d exp ok=%0d bad=%0d", name, cnt_ok, cnt_bad, exp_ok, exp_bad);
        end
        n_tests++;
        if ({link_up, link_speed, link_fdx} !== {exp_up, exp_speed, exp_fdx}) begin
            n_fail++; $display("FAIL %s status got %b%b%b exp %b%b%b", name, link_up, link_speed, link_fdx, exp_up, exp_speed, exp_fdx);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_good_frame();
        fill(64, 1'b0, -1);
        send_frame(7, 64, 2);
        test_frames("good_frame");
    endtask

    task automatic test_err_byte();
        fill(64, 1'b0, 10);
        send_frame(7, 64, 2);
        test_frames("err_byte");
    endtask

    task automatic test_runt_long();
        fill(20, 1'b1, -1);
        send_frame(7, 20, 2);
        test_frames("runt");
        fill(1600, 1'b1, 1530);
        send_frame(7, 1600, 2);
        test_frames("long");
    endtask

    task automatic test_single_zero();
        send_frame(1, 0, 2);
        test_frames("zero_byte");
        fill(1, 1'b1, -1);
        send_frame(1, 1, 2);
        test_frames("single_byte");
    endtask

    task automatic test_status();
        idle_b = 8'hDD;
        repeat (3) drive(1'b0, 1'b0, 8'hDD);
        repeat (3) drive(1'b0, 1'b0, 8'h3A);
        repeat (3) drive(1'b0, 1'b1, 8'h00);
        test_frames("status");
        n_tests++;
        if ({link_up, link_speed, link_fdx} !== 4'b1101) begin
            n_fail++; $display("FAIL status_1g_fdx got %b%b%b exp 1101", link_up, link_speed, link_fdx);
        end
    endtask

    task automatic test_drop();
        logic [7:0] a[4] = '{8'hAB, 8'h55, 8'hD5, 8'h00};
        logic [7:0] b[6] = '{8'h55, 8'h55, 8'hAB, 8'hD5, 8'h11, 8'h22};
        foreach (a[i]) drive(1'b1, 1'b0, a[i]);
        drive(1'b0, 1'b0, idle_b);
        foreach (b[i]) drive(1'b1, 1'b0, b[i]);
        drive(1'b0, 1'b0, idle_b);
        test_frames("drop");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            fill(64 + f, 1'b1, f == 1 ? 5 : -1);
            send_frame(1 + f, 64 + f, 1);
        end
        test_frames("back_to_back");
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(0, 150);
            for (int i = 0; i < n; i++) begin
                pl[i] = 8'($urandom);
                pe[i] = $urandom_range(0, 99) == 0;
            end
            idle_b = 8'($urandom);
            send_frame($urandom_range(1, 8), n, $urandom_range(1, 3));
            repeat ($urandom_range(0, 3)) drive(1'b0, 1'($urandom), 8'($urandom));
        end
        idle_b = 8'hDD;
        test_frames("random");
    endtask

    task automatic test_mid_reset();
        fill(64, 1'b0, -1);
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, pl[i]);
        n_tests++;
        if (got_q.size() == 0) begin
            n_fail++; $display("FAIL mid_reset_in_frame got %0d bytes exp >0", got_q.size());
        end
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rx_valid, rx_eof, rx_data, cnt_ok, cnt_bad, link_up, link_speed, link_fdx} !== 46'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs got v=%b eof=%b d=%h ok=%h bad=%h link=%b%b%b exp 0",
                rx_valid, rx_eof, rx_data, cnt_ok, cnt_bad, link_up, link_speed, link_fdx);
        end
        exp_ok = 0; exp_bad = 0; exp_up = 0; exp_speed = 0; exp_fdx = 0;
        idle_b = 8'h00;
        repeat (4) drive(1'b0, 1'b0, idle_b);
        got_q.delete();
        exp_q.delete();
        sys_rst_n = 1'b1;
        fill(70, 1'b1, -1);
        send_frame(7, 70, 2);
        test_frames("after_reset");
    endtask

    initial begin
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        test_reset();
        sys_rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        test_good_frame();
        test_err_byte();
        test_runt_long();
        test_single_zero();
        test_status();
        test_drop();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
